// File: rtl/mask_index_streamer_pkg.sv
// Core-wide constants and state encoding shared by the mask walker
// and anything else that deals in register indices.
package mask_index_streamer_pkg;

  localparam int REG_IDX_W   = 5;
  localparam int XLEN_MASK_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mask_index_streamer_pri_enc.sv
// Combinational priority encoder: index of the lowest (or highest) set bit,
// plus an any-set flag. Index is 0 when no bit is set.
module pri_enc_32to5 #(
  parameter int WIDTH     = 32,
  parameter int IDX_W     = $clog2(WIDTH),
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan toward the preferred end so the winning bit is written last.
  always_comb begin
    idx = '0;
    any = |vec;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++)
        if (vec[i]) idx = IDX_W'(i);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/mask_index_streamer.sv
// Walks a bit mask and streams out the index of each set bit, one per
// valid/ready handshake, with a done pulse once the mask is exhausted.
module mask_index_streamer
  import mask_index_streamer_pkg::*;
#(
  parameter int WIDTH     = XLEN_MASK_W,
  parameter int IDX_W     = $clog2(WIDTH),
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             done
);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] pend, pend_nxt;
  logic             done_nxt;
  logic             any;
  logic             single;

  pri_enc_32to5 #(
    .WIDTH    (WIDTH),
    .IDX_W    (IDX_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_enc (
    .vec(pend),
    .idx(out_idx),
    .any(any)
  );

  assign single    = any && ((pend & (pend - WIDTH'(1))) == '0);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == BUSY);
  assign out_last  = out_valid && single;

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    done_nxt  = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      pend_nxt  = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            // An empty mask completes immediately without entering BUSY.
            if (|in_mask) begin
              pend_nxt  = in_mask;
              state_nxt = BUSY;
            end else begin
              done_nxt = 1'b1;
            end
          end
        end
        BUSY: begin
          if (out_ready) begin
            pend_nxt = pend & ~(WIDTH'(1) << out_idx);
            if (out_last) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_mask_index_streamer.sv
// Randomized self-checking bench: LSB-first and MSB-first instances share
// stimulus; expected beats come from a queue built straight from the mask.
module tb_mask_index_streamer;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_mask;
  logic        in_ready0, out_valid0, out_last0, done0;
  logic [4:0]  out_idx0;
  logic        in_ready1, out_valid1, out_last1, done1;
  logic [4:0]  out_idx1;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mask_index_streamer #(.MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_mask(in_mask), .out_valid(out_valid0), .out_ready(out_ready),
    .out_idx(out_idx0), .out_last(out_last0), .done(done0)
  );

  mask_index_streamer #(.MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_mask(in_mask), .out_valid(out_valid1), .out_ready(out_ready),
    .out_idx(out_idx1), .out_last(out_last1), .done(done1)
  );

  // rdy_mode: 0 = always ready, 1 = toggle starting low, 2 = random.
  task automatic do_walk(input logic [31:0] mask, input bit msb, input int rdy_mode,
                         input int exp_busy, input string name);
    int   q[$];
    int   busy, cyc;
    bit   tog, rdy;
    logic ov, ol, dn, ir;
    logic [4:0] oi;
    for (int i = 0; i < 32; i++)
      if (mask[i]) begin
        if (msb) q.push_front(i); else q.push_back(i);
      end
    @(negedge clk);
    ir = msb ? in_ready1 : in_ready0;
    compared++;
    if (ir !== 1'b1) begin
      mismatched++;
      $display("FAIL %s idle_ready: got %b want 1", name, ir);
    end
    in_valid = 1'b1; in_mask = mask; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    busy = 0; cyc = 0; tog = 1'b0;
    while (q.size() > 0 && cyc < 2000) begin
      ov = msb ? out_valid1 : out_valid0;
      oi = msb ? out_idx1   : out_idx0;
      ol = msb ? out_last1  : out_last0;
      dn = msb ? done1      : done0;
      ir = msb ? in_ready1  : in_ready0;
      compared++;
      if (ov !== 1'b1 || oi !== 5'(q[0]) || ol !== (q.size() == 1) || dn !== 1'b0 || ir !== 1'b0) begin
        mismatched++;
        $display("FAIL %s beat: got v=%b idx=%0d last=%b done=%b rdy=%b want v=1 idx=%0d last=%b done=0 rdy=0",
                 name, ov, oi, ol, dn, ir, q[0], q.size() == 1);
      end
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       begin rdy = tog; tog = ~tog; end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      busy++;
      @(negedge clk);
      if (rdy) void'(q.pop_front());
      cyc++;
    end
    out_ready = 1'b0;
    ov = msb ? out_valid1 : out_valid0;
    dn = msb ? done1      : done0;
    ir = msb ? in_ready1  : in_ready0;
    compared++;
    if (cyc >= 2000 || ov !== 1'b0 || dn !== 1'b1 || ir !== 1'b1) begin
      mismatched++;
      $display("FAIL %s end: got v=%b done=%b rdy=%b cyc=%0d want v=0 done=1 rdy=1", name, ov, dn, ir, cyc);
    end
    if (exp_busy >= 0) begin
      compared++;
      if (busy != exp_busy) begin
        mismatched++;
        $display("FAIL %s busy_cycles: got %0d want %0d", name, busy, exp_busy);
      end
    end
    @(negedge clk);
    dn = msb ? done1 : done0;
    ov = msb ? out_valid1 : out_valid0;
    compared++;
    if (dn !== 1'b0 || ov !== 1'b0) begin
      mismatched++;
      $display("FAIL %s done_once: got done=%b v=%b want 0 0", name, dn, ov);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mask = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    compared++;
    if ({in_ready0, out_valid0, out_idx0, out_last0, done0} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0} ||
        {in_ready1, out_valid1, out_idx1, out_last1, done1} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset: got %b%b%0d%b%b / %b%b%0d%b%b want 1 0 0 0 0",
               in_ready0, out_valid0, out_idx0, out_last0, done0,
               in_ready1, out_valid1, out_idx1, out_last1, done1);
    end
  endtask

  task automatic test_basic();
    do_walk(32'h0000_0013, 1'b0, 0, 3, "basic_lsb");
  endtask

  task automatic test_empty();
    do_walk(32'h0000_0000, 1'b0, 0, -1, "empty_mask");
  endtask

  task automatic test_all_ones_stall();
    do_walk(32'hFFFF_FFFF, 1'b0, 1, 64, "all_ones_toggle");
  endtask

  task automatic test_msb_first();
    do_walk(32'h8000_0001, 1'b1, 0, 2, "msb_first");
    do_walk(32'hFFFF_FFFF, 1'b1, 0, 32, "msb_all_ones");
  endtask

  task automatic test_flush();
    @(negedge clk);
    in_valid = 1'b1; in_mask = 32'h0000_00F0; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    compared++;
    if (out_valid0 !== 1'b1 || out_idx0 !== 5'd4) begin
      mismatched++;
      $display("FAIL flush_first_beat: got v=%b idx=%0d want v=1 idx=4", out_valid0, out_idx0);
    end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    compared++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || done0 !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_idle: got v=%b rdy=%b done=%b want 0 1 0", out_valid0, in_ready0, done0);
    end
    @(negedge clk);
    compared++;
    if (out_valid0 !== 1'b0 || done0 !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_no_done: got v=%b done=%b want 0 0", out_valid0, done0);
    end
    do_walk(32'h0000_0002, 1'b0, 0, 1, "after_flush");
  endtask

  task automatic test_reset_mid_walk();
    @(negedge clk);
    in_valid = 1'b1; in_mask = 32'h0000_00F0; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_mask = 32'h0000_0005;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    compared++;
    if ({in_ready0, out_valid0, out_idx0, out_last0, done0} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_mid: got rdy=%b v=%b idx=%0d last=%b done=%b want 1 0 0 0 0",
               in_ready0, out_valid0, out_idx0, out_last0, done0);
    end
    @(negedge clk);
    compared++;
    if (out_valid0 !== 1'b0 || done0 !== 1'b0 || in_ready0 !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_no_capture: got v=%b done=%b rdy=%b want 0 0 1", out_valid0, done0, in_ready0);
    end
  endtask

  task automatic test_random();
    logic [31:0] m;
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0:       m = $urandom & $urandom & $urandom;
        1:       m = 32'(1) << $urandom_range(0, 31);
        2:       m = (n % 6 == 0) ? 32'h0 : $urandom;
        default: m = $urandom;
      endcase
      do_walk(m, 1'(n % 2), 2, -1, "random");
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mask = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_empty();
    test_all_ones_stall();
    test_msb_first();
    test_flush();
    test_reset_mid_walk();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
